mips_rtype_seq_ctrl: RTL
========================

// Module: mips_rtype_seq_ctrl
// PURPOSE
//  Multi-cycle control FSM that sequences the R-type ALU datapath (PC, PC adder, instruction
//  memory, instruction register, register file, ALU control, MIPS ALU). Replaces free-running
//  per-edge updates with explicit FETCH/DECODE/EXECUTE/WRITEBACK steps, plus a memory-ready
//  handshake, illegal-instruction halt and a retired-instruction counter.
// PARAMETERS
//  RTYPE_OP  6'h00  opcode value [31:26] accepted as R-type; any other opcode is illegal
//  CNT_W     16     width of RETIRED counter
// PORTS
//  CLK          in   1      clock; all state changes on posedge
//  RESET_N      in   1      asynchronous reset, active low
//  RUN          in   1      level; 1 = sequence instructions, 0 = stop at next instruction boundary
//  INSTRUCTION  in   32     instruction word from instruction memory
//  IMEM_READY   in   1      INSTRUCTION valid this cycle (sampled only in FETCH)
//  IMEM_REQ     out  1      fetch request to instruction memory
//  IR_LOAD      out  1      1-cycle pulse: instruction register captures INSTRUCTION
//  PC_WRITE     out  1      1-cycle pulse: PC <= PC + 4
//  ALU_OP       out  2      2'b00 idle/add, 2'b10 decode by funct
//  REG_WRITE    out  1      1-cycle pulse: register file writes ALU result to rd
//  FUNC_CODE    out  6      funct field latched in DECODE
//  BUSY         out  1      1 in FETCH, DECODE, EXECUTE, WRITEBACK
//  HALTED       out  1      1 in HALT
//  RETIRED      out  CNT_W  count of completed instructions
//  STATE        out  3      current state encoding (debug)
// BEHAVIOUR
//  - States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5; 6,7 unreachable -> IDLE.
//  - Reset (RESET_N=0, async): STATE=IDLE; all outputs 0; FUNC_CODE=0; RETIRED=0. Reset mid-
//    instruction aborts immediately; no REG_WRITE/PC_WRITE for the aborted instruction.
//  - IDLE: RUN=1 -> FETCH; else stay.
//  - FETCH: IMEM_REQ=1 (Moore). IMEM_READY=1 -> IR_LOAD=1 and PC_WRITE=1 same cycle
//    (combinational from state & IMEM_READY), internal copy of INSTRUCTION captured, -> DECODE.
//    IMEM_READY=0 and RUN=1 -> stay; IMEM_READY=0 and RUN=0 -> IDLE, no pulses.
//  - DECODE: FUNC_CODE <= captured[5:0]. Legal iff captured[31:26]==RTYPE_OP and funct in
//    {6'h20 ADD,6'h22 SUB,6'h24 AND,6'h25 OR,6'h27 NOR,6'h2A SLT}. Legal -> EXECUTE; else HALT.
//  - EXECUTE: ALU_OP=2'b10 -> WRITEBACK unconditionally (RUN ignored).
//  - WRITEBACK: ALU_OP=2'b10, REG_WRITE=1, RETIRED <= RETIRED+1 (wraps to 0 at all-ones).
//    RUN=1 -> FETCH; RUN=0 -> IDLE.
//  - HALT: HALTED=1, all strobes 0; exits only via reset; RUN and IMEM_READY ignored.
//  - Latency: min 4 cycles/instruction (FETCH..WRITEBACK) with IMEM_READY=1; each FETCH stall
//    cycle adds 1. REG_WRITE exactly 3 cycles after the IR_LOAD cycle.
//  - IR_LOAD, PC_WRITE, REG_WRITE never high together; at most one each per instruction.
//  - ALU_OP=2'b00 in IDLE, FETCH, DECODE, HALT. FUNC_CODE holds until next DECODE.
//  - IMEM_READY outside FETCH has no effect. RUN deassertion takes effect only in IDLE, FETCH
//    (while stalled) or at WRITEBACK exit; a started instruction always completes.
// TESTING
//  1 Reset/idle: RESET_N=0 then 1, RUN=0, 10 cycles -> STATE=0, all outputs 0, RETIRED=0.
//  2 ADD: INSTRUCTION=32'h00011020, IMEM_READY=1, RUN=1 -> IR_LOAD/PC_WRITE cycle 1, ALU_OP=10
//    cycles 3-4, REG_WRITE cycle 4, FUNC_CODE=6'h20, RETIRED=1, back in FETCH cycle 5.
//  3 Fetch stall: IMEM_READY=0 for 3 FETCH cycles then 1 -> IMEM_REQ high 4 cycles, single
//    IR_LOAD on 4th, REG_WRITE on cycle 7.
//  4 Illegal: funct 6'h00 (and separately opcode 6'h02) -> HALT after DECODE, HALTED=1,
//    no REG_WRITE, RETIRED unchanged; RUN toggling ignored until RESET_N pulse -> IDLE.
//  5 RUN drop during EXECUTE -> REG_WRITE still issued, RETIRED+1, then STATE=IDLE.
//  6 Async reset during EXECUTE -> outputs 0 before next CLK edge, no REG_WRITE; with CNT_W=4,
//    17 back-to-back SUB (32'h01495822) -> RETIRED wraps 15 -> 0 -> 1.

Source files
------------

// File: rtl/mips_rtype_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mips_rtype_seq_ctrl
//  Purpose  : Multi-cycle control sequencer for the R-type ALU datapath.
//             Steps each instruction through FETCH, DECODE, EXECUTE and
//             WRITEBACK. Includes an instruction-memory ready handshake, a halt
//             on illegal instructions, and a retired-instruction counter.
//  Ports    : CLK, RESET_N (async, active low)
//             RUN          - level, keep sequencing instructions
//             INSTRUCTION  - word from instruction memory
//             IMEM_READY   - INSTRUCTION valid (looked at only in FETCH)
//             IMEM_REQ     - fetch request (Moore, FETCH)
//             IR_LOAD      - pulse, instruction register captures INSTRUCTION
//             PC_WRITE     - pulse, PC <= PC + 4
//             ALU_OP       - 00 idle/add, 10 decode by funct
//             REG_WRITE    - pulse, register file writes rd
//             FUNC_CODE    - funct field latched in DECODE
//             BUSY/HALTED  - status
//             RETIRED      - completed-instruction count (wraps)
//             STATE        - current state encoding (debug)
//  Revision : 1.0  initial release
// ============================================================================
module mips_rtype_seq_ctrl #(
   parameter logic [5:0] RTYPE_OP = 6'h00,
   parameter int         CNT_W    = 16
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             RUN,
   input  logic [31:0]      INSTRUCTION,
   input  logic             IMEM_READY,
   output logic             IMEM_REQ,
   output logic             IR_LOAD,
   output logic             PC_WRITE,
   output logic [1:0]       ALU_OP,
   output logic             REG_WRITE,
   output logic [5:0]       FUNC_CODE,
   output logic             BUSY,
   output logic             HALTED,
   output logic [CNT_W-1:0] RETIRED,
   output logic [2:0]       STATE
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALT      = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t             r_state;
   state_t             w_next;
   logic [5:0]         r_ir_op;
   logic [5:0]         r_ir_funct;
   logic [5:0]         r_func;
   logic [CNT_W-1:0]   r_retired;
   logic               w_funct_ok;
   logic               w_legal;

   // Only the opcode and funct fields steer the sequencer; the register
   // specifiers are consumed by the datapath's own instruction register.
   logic               w_unused_instr;
   assign w_unused_instr = ^INSTRUCTION[25:6];

   always_comb begin
      w_funct_ok = 1'b0;
      case (r_ir_funct)
         6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A: w_funct_ok = 1'b1;
         default:                                 w_funct_ok = 1'b0;
      endcase
   end

   assign w_legal = (r_ir_op == RTYPE_OP) && w_funct_ok;

   // Next state and strobes. IR_LOAD/PC_WRITE are Mealy on IMEM_READY so that
   // the capture happens in the same cycle the memory reports valid data.
   always_comb begin
      w_next    = r_state;
      IMEM_REQ  = 1'b0;
      IR_LOAD   = 1'b0;
      PC_WRITE  = 1'b0;
      ALU_OP    = 2'b00;
      REG_WRITE = 1'b0;
      BUSY      = 1'b0;
      HALTED    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (RUN) w_next = S_FETCH;
         end
         S_FETCH: begin
            IMEM_REQ = 1'b1;
            BUSY     = 1'b1;
            if (IMEM_READY) begin
               IR_LOAD  = 1'b1;
               PC_WRITE = 1'b1;
               w_next   = S_DECODE;
            end else if (!RUN) begin
               // Stop is only honoured while no word has been taken yet.
               w_next = S_IDLE;
            end
         end
         S_DECODE: begin
            BUSY   = 1'b1;
            w_next = w_legal ? S_EXECUTE : S_HALT;
         end
         S_EXECUTE: begin
            BUSY   = 1'b1;
            ALU_OP = 2'b10;
            w_next = S_WRITEBACK;
         end
         S_WRITEBACK: begin
            BUSY      = 1'b1;
            ALU_OP    = 2'b10;
            REG_WRITE = 1'b1;
            w_next    = RUN ? S_FETCH : S_IDLE;
         end
         S_HALT: begin
            // Sticky until reset; RUN and IMEM_READY are deliberately ignored.
            HALTED = 1'b1;
            w_next = S_HALT;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state    <= S_IDLE;
         r_ir_op    <= 6'h00;
         r_ir_funct <= 6'h00;
         r_func     <= 6'h00;
         r_retired  <= '0;
      end else begin
         r_state <= w_next;
         if (IR_LOAD) begin
            r_ir_op    <= INSTRUCTION[31:26];
            r_ir_funct <= INSTRUCTION[5:0];
         end
         if (r_state == S_DECODE) begin
            r_func <= r_ir_funct;
         end
         if (r_state == S_WRITEBACK) begin
            r_retired <= r_retired + C_CNT_ONE;
         end
      end
   end

   assign FUNC_CODE = r_func;
   assign RETIRED   = r_retired;
   assign STATE     = r_state;

endmodule
`default_nettype wire
